// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings,
// supported opcodes and the datapath mux/ALU select codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory watchdog: counts consecutive stalled cycles in a memory state and
// raises a sticky timeout once the count reaches WAIT_LIMIT.
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic in_mem_state,
    input  logic entering,
    input  logic mem_ready,
    output logic timeout
);

    logic [7:0] r_count;
    logic       r_timeout;
    logic       w_stall;
    logic [8:0] w_count_inc;

    assign w_stall     = in_mem_state & ~mem_ready & ~entering;
    assign w_count_inc = {1'b0, r_count} + 9'd1;

    // Stall counter with saturation, plus the sticky flag. The flag sets on the
    // stalled cycle that brings the count to the limit, so a mem_ready in that
    // cycle completes the access instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if (entering || mem_ready) begin
                r_count <= 8'd0;
            end else if (w_stall && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
            if (w_stall && (w_count_inc >= 9'(WAIT_LIMIT))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/write-back, with a mem_req/mem_ready handshake and memory watchdog.
module mc_control
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_mem_req, w_ir_write, w_pc_write, w_branch, w_mem_write;
    logic       w_reg_write, w_illegal;
    logic       w_entering, w_in_mem;
    logic       w_unused;

    // zero only qualifies Branch inside the datapath.
    assign w_unused = zero;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_next;
    end

    // Next-state and Moore outputs (FETCH enables are mem_ready-qualified).
    always_comb begin
        w_state_next = S_FETCH;
        w_mem_req    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        IorD         = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        ALUOp        = ALUOP_ADD;
        PCSrc        = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                w_ir_write   = mem_ready;
                w_pc_write   = mem_ready;
                w_state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
                case (op)
                    OP_RTYPE:     w_state_next = S_EXEC;
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JUMP;
                    default: begin
                        w_illegal    = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                w_state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_req    = 1'b1;
                IorD         = 1'b1;
                w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req    = 1'b1;
                IorD         = 1'b1;
                w_mem_write  = 1'b1;
                w_state_next = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_REG;
                ALUOp        = ALUOP_FUNCT;
                w_state_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                RegDst      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_REG;
                ALUOp    = ALUOP_SUB;
                PCSrc    = PCSRC_ALUOUT;
                w_branch = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_IMM;
                w_state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                PCSrc      = PCSRC_JUMP;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Strobes are forced low while reset is held; selects follow FETCH.
    assign mem_req    = w_mem_req   & reset;
    assign IRWrite    = w_ir_write  & reset;
    assign PCWrite    = w_pc_write  & reset;
    assign Branch     = w_branch    & reset;
    assign MemWrite   = w_mem_write & reset;
    assign RegWrite   = w_reg_write & reset;
    assign illegal_op = w_illegal   & reset;
    assign state_o    = r_state;

    assign w_in_mem   = is_mem_state(r_state);
    assign w_entering = is_mem_state(w_state_next) && (w_state_next != r_state);

    mc_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_wait_timer (
        .clk          (clk),
        .reset        (reset),
        .in_mem_state (w_in_mem),
        .entering     (w_entering),
        .mem_ready    (mem_ready),
        .timeout      (mem_timeout)
    );

endmodule

// File: tb/tb_mc_control.sv
// Randomized instruction-level bench for mc_control: each instruction is
// expanded into its phase list (with wait states) and every cycle is checked.
module tb_mc_control;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero, mem_ready;
    logic       mem_req, IorD, IRWrite, PCWrite, Branch, MemWrite, RegWrite;
    logic       RegDst, MemtoReg, ALUSrcA, illegal_op, mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    mc_control #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .Branch(Branch), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
    );

    typedef struct packed {
        logic       mem_req, IorD, IRWrite, PCWrite, Branch, MemWrite;
        logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSrc;
        logic       illegal;
    } ctl_t;

    typedef struct {
        int st;
        bit rdy;
        bit to_after;
    } step_t;

    step_t q[$];
    int    vectors = 0;
    int    errs    = 0;
    bit    exp_to  = 1'b0;
    bit    cur_ill = 1'b0;

    // Control word each phase must show, straight from the state descriptions.
    function automatic ctl_t exp_ctl(input int st, input bit rdy, input bit ill);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_req = 1; c.ALUSrcB = 2'b01; c.IRWrite = rdy; c.PCWrite = rdy; end
            1:  begin c.ALUSrcB = 2'b11; c.illegal = ill; end
            2:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            3:  begin c.mem_req = 1; c.IorD = 1; end
            4:  begin c.RegWrite = 1; c.MemtoReg = 1; end
            5:  begin c.mem_req = 1; c.IorD = 1; c.MemWrite = 1; end
            6:  begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
            7:  begin c.RegWrite = 1; c.RegDst = 1; end
            8:  begin c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCSrc = 2'b01; c.Branch = 1; end
            9:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            10: begin c.RegWrite = 1; end
            11: begin c.PCWrite = 1; c.PCSrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t obs_ctl();
        return {mem_req, IorD, IRWrite, PCWrite, Branch, MemWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, illegal_op};
    endfunction

    // 0 R, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 unsupported
    function automatic int op_class(input logic [5:0] o);
        case (o)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 5;
            default:   return 6;
        endcase
    endfunction

    // A memory phase: `waits` stalled cycles then the completing cycle.
    task automatic push_mem(input int st, input int waits);
        step_t s;
        for (int k = 1; k <= waits; k++) begin
            s.st = st; s.rdy = 1'b0; s.to_after = (k >= LIMIT);
            q.push_back(s);
        end
        s.st = st; s.rdy = 1'b1; s.to_after = 1'b0;
        q.push_back(s);
    endtask

    // A single-cycle phase; mem_ready is random there and must be ignored.
    task automatic push_plain(input int st);
        step_t s;
        s.st = st; s.rdy = 1'($urandom_range(0, 1)); s.to_after = 1'b0;
        q.push_back(s);
    endtask

    task automatic build_instr(input logic [5:0] o, input bit z, input int wf, input int wm);
        op = o; zero = z; q.delete();
        cur_ill = (op_class(o) == 6);
        push_mem(0, wf);
        push_plain(1);
        case (op_class(o))
            0: begin push_plain(6); push_plain(7); end
            1: begin push_plain(2); push_mem(3, wm); push_plain(4); end
            2: begin push_plain(2); push_mem(5, wm); end
            3: push_plain(8);
            4: begin push_plain(9); push_plain(10); end
            5: push_plain(11);
            default: ;
        endcase
    endtask

    // Runs one cycle: drive, check at negedge, advance past the edge.
    task automatic step(input step_t s);
        ctl_t e, o;
        mem_ready = s.rdy;
        @(negedge clk);
        e = exp_ctl(s.st, s.rdy, cur_ill && (s.st == 1));
        o = obs_ctl();
        vectors++;
        assert (state_o === 4'(s.st)) else begin
            errs++; $error("FAIL state got=%0d exp=%0d", state_o, s.st);
        end
        vectors++;
        assert (o === e) else begin
            errs++; $error("FAIL ctl st=%0d got=%h exp=%h", s.st, o, e);
        end
        vectors++;
        assert (mem_timeout === exp_to) else begin
            errs++; $error("FAIL timeout st=%0d got=%b exp=%b", s.st, mem_timeout, exp_to);
        end
        @(posedge clk); #1;
        if (s.to_after) exp_to = 1'b1;
    endtask

    task automatic exec_steps(input int n);
        int lim;
        lim = (n < q.size()) ? n : q.size();
        for (int i = 0; i < lim; i++) step(q[i]);
    endtask

    task automatic run_instr(input logic [5:0] o, input bit z, input int wf, input int wm);
        build_instr(o, z, wf, wm);
        exec_steps(q.size());
        $display("instr op=%b zero=%b fetch_waits=%0d mem_waits=%0d cycles=%0d timeout=%b",
                 o, z, wf, wm, q.size(), exp_to);
    endtask

    // One cycle with reset held: FETCH selects, all strobes low, flag clear.
    task automatic reset_cycle();
        ctl_t e, o;
        @(negedge clk);
        e = exp_ctl(0, 1'b0, 1'b0);
        e.mem_req = 1'b0;
        o = obs_ctl();
        vectors++;
        assert (state_o === 4'd0) else begin
            errs++; $error("FAIL rst_state got=%0d exp=0", state_o);
        end
        vectors++;
        assert (o === e) else begin
            errs++; $error("FAIL rst_ctl got=%h exp=%h", o, e);
        end
        vectors++;
        assert (mem_timeout === 1'b0) else begin
            errs++; $error("FAIL rst_timeout got=%b exp=0", mem_timeout);
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        repeat (3) reset_cycle();
        reset = 1'b1; exp_to = 1'b0;
        $display("reset released");

        // Directed instructions
        run_instr(6'b000000, 1'b0, 0, 0);
        run_instr(6'b100011, 1'b0, 2, 1);
        run_instr(6'b101011, 1'b0, 0, 3);
        run_instr(6'b000100, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(6'b001000, 1'b0, 1, 0);
        run_instr(6'b000010, 1'b0, LIMIT - 1, 0);

        // Random instruction mix, waits kept below the watchdog limit
        for (int n = 0; n < 40; n++) begin
            logic [5:0] o;
            logic [5:0] tbl [6];
            tbl = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
            if ($urandom_range(0, 7) < 6) o = tbl[$urandom_range(0, 5)];
            else                          o = 6'($urandom);
            run_instr(o, 1'($urandom_range(0, 1)), $urandom_range(0, LIMIT - 1),
                      $urandom_range(0, LIMIT - 1));
        end

        // Reset mid-instruction (lw parked in MEMRD), then a clean R-type
        build_instr(6'b100011, 1'b0, 0, 2);
        exec_steps(3);
        mem_ready = 1'b0;
        #2 reset = 1'b0;
        reset_cycle();
        reset = 1'b1;
        $display("reset mid-instruction");
        run_instr(6'b000000, 1'b0, 0, 0);

        // Watchdog: long FETCH stall sets the flag, which then sticks
        run_instr(6'b000010, 1'b0, LIMIT + 2, 0);
        run_instr(6'b000000, 1'b0, 0, 0);
        run_instr(6'b101011, 1'b0, 0, 1);

        // Reset during a stall clears the flag
        build_instr(6'b000010, 1'b0, LIMIT + 1, 0);
        exec_steps(2);
        mem_ready = 1'b0;
        #2 reset = 1'b0;
        exp_to = 1'b0;
        reset_cycle();
        reset = 1'b1;
        $display("reset mid-stall");
        run_instr(6'b001000, 1'b0, 1, 0);
        run_instr(6'b100011, 1'b0, 0, LIMIT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle MIPS main control unit. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the datapath enables and mux selects. Its `IRWrite` output loads the instruction register, and it decodes the opcode that the instruction register returns. Memory accesses use a `mem_req`/`mem_ready` handshake, so fetch and load/store stall on wait states. A watchdog flags memory that never responds.

## Interface
- `WAIT_LIMIT`, default 255: consecutive stalled cycles in one memory state before `mem_timeout` sets; legal range 1..255.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `op`  in  6  opcode, instruction register bits [31:26].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  out  1  instruction register load.
- `PCWrite`  out  1  unconditional PC load.
- `Branch`  out  1  conditional PC load; PC enable = `PCWrite | (Branch & zero)`, formed in the datapath.
- `MemWrite`  out  1  memory write.
- `RegWrite`  out  1  register file write.
- `RegDst`  out  1  destination register select: 0 = rt, 1 = rd.
- `MemtoReg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = register A.
- `ALUSrcB`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  2  ALU operation: 00 = add, 01 = subtract, 10 = decode from funct.
- `PCSrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode is unsupported.
- `mem_timeout`  out  1  sticky flag; cleared only by reset.
- `state_o`  out  4  current state, for debug.

## Operation
- Moore FSM with a 4-bit state register. Outputs are combinational from the state, except the `mem_ready`-qualified terms noted below. Any output not listed for a state is 0.
- **FETCH:**
  - Drives `mem_req=1`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUOp=00`, `PCSrc=00`.
  - Drives `IRWrite = PCWrite = mem_ready`.
  - Goes to DECODE when `mem_ready=1`; otherwise stays in FETCH.
- **DECODE:** drives `ALUSrcA=0`, `ALUSrcB=11`, `ALUOp=00`. Next state by opcode:
  - 000000 (R-type) → EXEC
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JUMP
  - any other opcode → FETCH, with `illegal_op=1` for that cycle.
- **MEMADR:** drives `ALUSrcA=1`, `ALUSrcB=10`. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD:** drives `mem_req=1`, `IorD=1`. Goes to MEMWB when `mem_ready=1`.
- **MEMWB:** drives `RegWrite=1`, `MemtoReg=1`, `RegDst=0`. Goes to FETCH.
- **MEMWR:** drives `mem_req=1`, `IorD=1`, `MemWrite=1` for every cycle in the state. Goes to FETCH when `mem_ready=1`.
- **EXEC:** drives `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=10`. Goes to ALUWB.
- **ALUWB:** drives `RegWrite=1`, `RegDst=1`. Goes to FETCH.
- **BRANCH:** drives `ALUSrcA=1`, `ALUSrcB=00`, `ALUOp=01`, `PCSrc=01`, `Branch=1`. Goes to FETCH.
- **ADDIEX:** drives `ALUSrcA=1`, `ALUSrcB=10`. Goes to ADDIWB.
- **ADDIWB:** drives `RegWrite=1`, `RegDst=0`. Goes to FETCH.
- **JUMP:** drives `PCWrite=1`, `PCSrc=10`. Goes to FETCH.
- Unused state encodings go to FETCH on the next clock.
- **Watchdog:**
  - 8-bit counter clears on entry to a memory state (FETCH, MEMRD, MEMWR) and on every cycle with `mem_ready=1`.
  - It increments on each stalled cycle in a memory state and saturates at 255.
  - When it reaches `WAIT_LIMIT`, `mem_timeout` sets to 1. The FSM does not abort; it keeps waiting for `mem_ready`.

## Timing
- **Reset:** `reset=0` forces state = FETCH, watchdog counter = 0, `mem_timeout=0`.
  - While `reset=0`, `IRWrite`, `PCWrite`, `Branch`, `MemWrite`, `RegWrite`, `mem_req` and `illegal_op` are gated to 0.
  - Mux selects show FETCH values during reset.
  - Asserting reset mid-instruction abandons the instruction. The first edge after release starts in FETCH.
- **Cycles per instruction with zero wait states:** R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, illegal 2.
- Each wait state adds exactly one cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` outside a memory state is ignored.
- **IR latency:** `IRWrite` and `mem_ready` are sampled together at the FETCH exit edge, so the new instruction is visible in DECODE.
- **Watchdog edge case:** a `mem_ready=1` in the same cycle the counter reaches `WAIT_LIMIT` completes the access and suppresses the timeout.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings (FETCH = 0 … JUMP = 11)
  - opcode constants
  - `ALUOp`, `ALUSrcB` and `PCSrc` codes.
- One sub-module, `mc_wait_timer`, contains the watchdog counter and sticky flag. Its inputs are `clk`, `reset`, `in_mem_state`, `entering`, `mem_ready`; its output is `timeout`.

## Test plan
- **Reset then R-type:**
  - Hold `reset=0` for 3 cycles; then R-type (op=000000) with `mem_ready` tied to 1.
  - Required: all enables 0 during reset.
  - `state_o` sequence 0, 1, 6, 7, 0.
  - `IRWrite=1` only in cycle 0; `RegWrite=1`, `RegDst=1` in ALUWB.
- **lw with 2 wait states in FETCH and 1 in MEMRD:**
  - Required: 8 cycles total.
  - `IRWrite` pulses once, on the `mem_ready` cycle only.
  - `MemtoReg=1`, `RegWrite=1` in MEMWB.
- **sw with 3 wait states:** required `MemWrite=1` for all 4 MEMWR cycles, `IorD=1`, then FETCH.
- **beq:**
  - With `zero=1`, BRANCH shows `Branch=1`, `PCSrc=01`, `ALUOp=01`.
  - Repeat with `zero=0`: identical outputs, 3 cycles each.
- **Illegal opcode:** op=111111 gives a one-cycle `illegal_op` pulse in DECODE, then FETCH.
- **Watchdog:**
  - With `WAIT_LIMIT=4`, hold `mem_ready=0` in FETCH.
  - Required: `mem_timeout` rises on the 4th stalled cycle and stays high after a later `mem_ready`.
  - A mid-stall reset clears it.
